digit_ram_buf: RTL and testbench

- Parametrised simple dual-port digit RAM for the online-division datapath; successor to the fixed 2-bit x 128 digit store.
- Adds a reset-driven and on-demand hardware clear engine, a registered read port with valid strobe, and a selectable read-during-write mode.
- Sits between the digit-generation stage and residual/selection logic; one write port and one read port share one clock.

---
 rtl/digit_ram_buf.sv | 161 ++++++++++++++++
 tb/tb_digit_ram_buf.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/digit_ram_buf.sv
// ----------------------------------------------------------------------------
// digit_ram_buf
//
// Simple dual-port digit RAM for the online-division datapath. There is one
// write port and one registered read port, and both run on a single clock.
// A hardware clear engine writes INIT_VAL to every word after reset, and again
// whenever a clear is requested while the buffer is ready.
//
// Parameters:
//   DATA_WIDTH - bits per stored digit word
//   ADDR_WIDTH - address bits, depth = 2**ADDR_WIDTH
//   RDW_MODE   - same-address read-during-write: 0 = old data, 1 = new data
//   INIT_VAL   - value the clear engine writes to every word
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   clr        - full-memory clear request, sampled only while ready=1
//   data       - write data
//   write_addr - write address
//   we         - write enable
//   read_addr  - read address
//   re         - read enable
//   ready      - 1 = clear finished, reads and writes are accepted
//   q          - registered read data
//   q_valid    - one-cycle strobe, q holds data for an accepted read
//
// Handshake contract: a write (we) or read (re) is accepted on a rising edge
// only if ready=1 and clr=0 in that cycle. Otherwise it is dropped, and
// nothing is queued. An accepted read returns on the next edge: q_valid is
// high for exactly one cycle per accepted read. q keeps its last value while
// q_valid is low.
// ----------------------------------------------------------------------------
module digit_ram_buf #(
    parameter int                    DATA_WIDTH = 2,
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  re,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [ADDR_WIDTH-1:0]   clr_cnt_next;

    // Single physical write port, shared by the clear engine and the user.
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    rd_fire;
    logic                    rd_fwd;
    logic [DATA_WIDTH-1:0]   rd_data;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and write-port steering
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        mem_we       = 1'b0;
        mem_waddr    = write_addr;
        mem_wdata    = data;
        rd_fire      = 1'b0;

        unique case (state)
            S_CLEAR: begin
                // User we/re/clr are ignored. One word is cleared per edge,
                // and the counter wraps to 0 as the last word is written.
                mem_we       = 1'b1;
                mem_waddr    = clr_cnt;
                mem_wdata    = INIT_VAL;
                clr_cnt_next = clr_cnt + ADDR_ONE;
                if (clr_cnt == LAST_ADDR) begin
                    state_next = S_READY;
                end
            end
            S_READY: begin
                if (clr) begin
                    // A clear request wins over any access in the same cycle.
                    state_next   = S_CLEAR;
                    clr_cnt_next = '0;
                end else begin
                    mem_we  = we;
                    rd_fire = re;
                end
            end
            default: begin
                state_next   = S_CLEAR;
                clr_cnt_next = '0;
            end
        endcase
    end

    assign ready = (state == S_READY);

    // ------------------------------------------------------------------
    // Storage array: not reset, the clear engine initialises it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Same-address forwarding only in new-data mode. The array read itself
    // always returns the pre-edge contents.
    assign rd_fwd  = (RDW_MODE != 0) && mem_we && (mem_waddr == read_addr);
    assign rd_data = rd_fwd ? mem_wdata : mem[read_addr];

    // ------------------------------------------------------------------
    // Registered read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= rd_fire;
            if (rd_fire) begin
                q <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_digit_ram_buf.sv
// ----------------------------------------------------------------------------
// tb_digit_ram_buf
//
// Bench for digit_ram_buf. It instantiates three copies of the design:
//   u0 - default parameters (old-data read-during-write)
//   u1 - RDW_MODE=1, driven by the same inputs as u0
//   u2 - ADDR_WIDTH=4, INIT_VAL=2'b10, driven by its own inputs
//
// Read results for u0 and u1 are predicted when each read is issued. They are
// checked as the strobe arrives. All other checks are directed steps.
// ----------------------------------------------------------------------------
module tb_digit_ram_buf;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       clr;
  logic [1:0] data;
  logic [6:0] write_addr;
  logic       we;
  logic [6:0] read_addr;
  logic       re;

  logic       ready0, q_valid0, ready1, q_valid1;
  logic [1:0] q0, q1;

  logic       clr2, we2, re2;
  logic [1:0] data2;
  logic [3:0] write_addr2, read_addr2;
  logic       ready2, q_valid2;
  logic [1:0] q2;

  digit_ram_buf u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .data(data), .write_addr(write_addr),
    .we(we), .read_addr(read_addr), .re(re), .ready(ready0), .q(q0), .q_valid(q_valid0)
  );

  digit_ram_buf #(.RDW_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .data(data), .write_addr(write_addr),
    .we(we), .read_addr(read_addr), .re(re), .ready(ready1), .q(q1), .q_valid(q_valid1)
  );

  digit_ram_buf #(.DATA_WIDTH(2), .ADDR_WIDTH(4), .INIT_VAL(2'b10)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr2), .data(data2), .write_addr(write_addr2),
    .we(we2), .read_addr(read_addr2), .re(re2), .ready(ready2), .q(q2), .q_valid(q_valid2)
  );

  // ---------------- scoreboard state ----------------
  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [1:0] exp0_q[$];
  logic [1:0] exp1_q[$];
  int         cyc_q[$];
  logic [1:0] mdl[128];
  bit         m_ready;
  bit         mon_due;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: a strobe is expected exactly in the cycle recorded at issue time.
  always @(negedge clk) begin
    mon_due = (cyc_q.size() > 0) && (cyc_q[0] == cyc);
    chk("q_valid", {31'd0, q_valid0}, {31'd0, mon_due});
    chk("q_valid_rdw1", {31'd0, q_valid1}, {31'd0, mon_due});
    if (mon_due) begin
      void'(cyc_q.pop_front());
      chk("q", {30'd0, q0}, {30'd0, exp0_q.pop_front()});
      chk("q_rdw1", {30'd0, q1}, {30'd0, exp1_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle of u0/u1 stimulus, applied just after a rising edge.
  task automatic op(input logic w, input logic [6:0] wa, input logic [1:0] wd,
                    input logic r, input logic [6:0] ra, input logic c);
    @(posedge clk);
    #1;
    we = w; write_addr = wa; data = wd; re = r; read_addr = ra; clr = c;
    if (m_ready) begin
      if (c) begin
        m_ready = 1'b0;
        for (int i = 0; i < 128; i++) mdl[i] = 2'b00;
      end else begin
        if (r) begin
          exp0_q.push_back(mdl[ra]);
          exp1_q.push_back((w && (wa == ra)) ? wd : mdl[ra]);
          cyc_q.push_back(cyc + 1);
        end
        if (w) mdl[wa] = wd;
      end
    end
  endtask

  task automatic op_idle();
    op(1'b0, 7'd0, 2'b00, 1'b0, 7'd0, 1'b0);
  endtask

  // Call with rst_n released just after an edge; checks ready timing of u0 and u2.
  task automatic wait_ready();
    for (int e = 1; e <= 128; e++) begin
      op_idle();
      chk("ready_rise", {31'd0, ready0}, {31'd0, (e == 128)});
      chk("ready_rise_small", {31'd0, ready2}, {31'd0, (e >= 16)});
    end
    m_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; clr = 1'b0; data = 2'b00; write_addr = 7'd0; we = 1'b0;
    read_addr = 7'd0; re = 1'b0;
    clr2 = 1'b0; we2 = 1'b0; re2 = 1'b0; data2 = 2'b00; write_addr2 = 4'd0; read_addr2 = 4'd0;
    m_ready = 1'b0;
    for (int i = 0; i < 128; i++) mdl[i] = 2'b00;

    // Reset state
    #23;
    chk("rst_ready", {31'd0, ready0}, 32'd0);
    chk("rst_q", {30'd0, q0}, 32'd0);
    chk("rst_q_valid", {31'd0, q_valid0}, 32'd0);
    chk("rst_ready_small", {31'd0, ready2}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready();

    // Every word cleared to 0, back-to-back reads
    for (int i = 0; i < 128; i++) op(1'b0, 7'd0, 2'b00, 1'b1, 7'(i), 1'b0);
    op_idle();
    op_idle();

    // Small instance: every word holds INIT_VAL
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1 re2 = 1'b1; read_addr2 = 4'(i);
      @(posedge clk);
      #1 re2 = 1'b0;
      chk("small_q", {30'd0, q2}, 32'h2);
      chk("small_q_valid", {31'd0, q_valid2}, 32'd1);
    end

    // Writes, then consecutive reads
    op(1'b1, 7'd5, 2'b10, 1'b0, 7'd0, 1'b0);
    op(1'b1, 7'd127, 2'b01, 1'b0, 7'd0, 1'b0);
    op_idle();
    op_idle();
    op(1'b0, 7'd0, 2'b00, 1'b1, 7'd5, 1'b0);
    op(1'b0, 7'd0, 2'b00, 1'b1, 7'd127, 1'b0);
    op_idle();
    op_idle();

    // Read-during-write on the same address and on different addresses
    op(1'b1, 7'd9, 2'b11, 1'b0, 7'd0, 1'b0);
    op_idle();
    op(1'b1, 7'd9, 2'b01, 1'b1, 7'd9, 1'b0);
    op(1'b0, 7'd0, 2'b00, 1'b1, 7'd9, 1'b0);
    op(1'b1, 7'd10, 2'b10, 1'b1, 7'd9, 1'b0);
    op(1'b0, 7'd0, 2'b00, 1'b1, 7'd10, 1'b0);
    op_idle();
    op_idle();

    // Fill with nonzero data, random reads
    for (int i = 0; i < 128; i++) op(1'b1, 7'(i), 2'($urandom_range(1, 3)), 1'b0, 7'd0, 1'b0);
    for (int k = 0; k < 12; k++) op(1'b0, 7'd0, 2'b00, 1'b1, 7'($urandom_range(0, 127)), 1'b0);
    op_idle();

    // Clear together with write and read: clear wins, accesses dropped during clear
    op(1'b1, 7'd3, 2'b11, 1'b1, 7'd3, 1'b1);
    for (int e = 1; e <= 129; e++) begin
      if (e <= 128) op(1'b1, 7'(e), 2'b11, 1'b1, 7'(e), 1'b0);
      else op_idle();
      chk("clr_ready", {31'd0, ready0}, {31'd0, (e == 129)});
    end
    m_ready = 1'b1;
    op(1'b0, 7'd0, 2'b00, 1'b1, 7'd3, 1'b0);
    op(1'b0, 7'd0, 2'b00, 1'b1, 7'd5, 1'b0);
    op(1'b0, 7'd0, 2'b00, 1'b1, 7'd50, 1'b0);
    op(1'b0, 7'd0, 2'b00, 1'b1, 7'd127, 1'b0);
    op_idle();
    op_idle();

    // Reset in the middle of a clear
    op(1'b1, 7'd20, 2'b11, 1'b0, 7'd0, 1'b0);
    op(1'b0, 7'd0, 2'b00, 1'b1, 7'd20, 1'b0);
    op_idle();
    op_idle();
    op(1'b0, 7'd0, 2'b00, 1'b0, 7'd0, 1'b1);
    for (int e = 1; e <= 61; e++) op_idle();
    chk("q_hold_in_clear", {30'd0, q0}, 32'h3);
    chk("ready_mid_clear", {31'd0, ready0}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", {31'd0, ready0}, 32'd0);
    chk("async_rst_q", {30'd0, q0}, 32'd0);
    chk("async_rst_q_valid", {31'd0, q_valid0}, 32'd0);
    chk("async_rst_q_rdw1", {30'd0, q1}, 32'd0);
    chk("async_rst_ready_small", {31'd0, ready2}, 32'd0);
    chk("async_rst_q_small", {30'd0, q2}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready();
    chk("q_after_reset", {30'd0, q0}, 32'd0);
    op(1'b0, 7'd0, 2'b00, 1'b1, 7'd20, 1'b0);
    op(1'b0, 7'd0, 2'b00, 1'b1, 7'd0, 1'b0);
    op_idle();
    op_idle();
    op_idle();
    chk("scoreboard_drained", cyc_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
